// File: rtl/pc_pkg.sv
// Shared encodings for the program counter and ALU.
// Holds op codes, branch condition codes and ALU flag bit positions.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_OP_RESET = 3'b000,
        PC_OP_HOLD  = 3'b001,
        PC_OP_INC   = 3'b010,
        PC_OP_JREL  = 3'b011,
        PC_OP_BRC   = 3'b100,
        PC_OP_JABS  = 3'b101,
        PC_OP_CALL  = 3'b110,
        PC_OP_RET   = 3'b111
    } pc_op_e;

    localparam logic [1:0] COND_EQ     = 2'b00;
    localparam logic [1:0] COND_NE     = 2'b01;
    localparam logic [1:0] COND_GRT    = 2'b10;
    localparam logic [1:0] COND_ALWAYS = 2'b11;

    localparam int EQ_BIT  = 0;
    localparam int GRT_BIT = 1;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for CALL/RET.
// Ports:
//   clk, rst_n  - clock and async active-low reset
//   clr         - synchronous empty (occupancy back to zero)
//   push, pop   - write din on top / drop top entry (ignored when full / empty)
//   din         - address to push
//   dout        - current top of stack (undefined when empty)
//   full, empty - occupancy status
//   depth       - number of valid entries
module ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     depth
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);
    // Entry index width; at least one bit so DEPTH = 1 still elaborates.
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem [0:(1 << IDX_W) - 1];
    logic [DEPTH_W-1:0] cnt;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   top_idx;

    assign full    = (cnt == DEPTH_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign depth   = cnt;
    assign wr_idx  = IDX_W'(cnt);
    assign top_idx = IDX_W'(cnt - DEPTH_W'(1));
    assign dout    = mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + DEPTH_W'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - DEPTH_W'(1);
        end
    end

    // Contents need no reset: only entries below cnt are ever read.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with relative/absolute jumps, flag-conditional branches
// and a hardware return-address stack.
// Ports:
//   clk, rst_n  - clock and async active-low reset
//   op          - operation code (pc_op_e)
//   k           - signed relative offset in instructions
//   target      - absolute target for JABS/CALL
//   flags       - ALU flags (EQ_BIT, GRT_BIT used)
//   cond        - BRC condition select
//   stall       - hold all state (op RESET still acts)
//   addr_instr  - registered fetch address
//   depth       - return stack occupancy
//   stack_ovf   - sticky: CALL while stack full
//   stack_unf   - sticky: RET while stack empty
module pc_stack
    import pc_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    OFFSET_WIDTH = 8,
    parameter int                    STRIDE_LOG2  = 1,
    parameter int                    STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR   = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [2:0]                         op,
    input  logic [OFFSET_WIDTH-1:0]            k,
    input  logic [ADDR_WIDTH-1:0]              target,
    input  logic [7:0]                         flags,
    input  logic [1:0]                         cond,
    input  logic                               stall,
    output logic [ADDR_WIDTH-1:0]              addr_instr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_ovf,
    output logic                               stack_unf
);

    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] rel;
    logic [ADDR_WIDTH-1:0] k_ext;
    logic [ADDR_WIDTH-1:0] nxt;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic                  taken;
    logic                  push;
    logic                  pop;
    logic                  do_reset;
    logic                  set_ovf;
    logic                  set_unf;
    logic                  full;
    logic                  empty;
    logic                  unused_flags;

    // Only EQ and GRT steer branches; the other ALU flags are ignored.
    assign unused_flags = ^flags[7:2];

    assign k_ext = ADDR_WIDTH'($signed(k));
    assign inc   = addr_instr + (ADDR_WIDTH'(1) << STRIDE_LOG2);
    assign rel   = addr_instr + (k_ext << STRIDE_LOG2);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ:     taken = flags[EQ_BIT];
            COND_NE:     taken = !flags[EQ_BIT];
            COND_GRT:    taken = flags[GRT_BIT];
            COND_ALWAYS: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt      = addr_instr;
        push     = 1'b0;
        pop      = 1'b0;
        do_reset = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        if (op == PC_OP_RESET) begin
            do_reset = 1'b1;
            nxt      = RESET_ADDR;
        end else if (!stall) begin
            case (op)
                PC_OP_HOLD: nxt = addr_instr;
                PC_OP_INC:  nxt = inc;
                PC_OP_JREL: nxt = rel;
                PC_OP_BRC:  nxt = taken ? rel : inc;
                PC_OP_JABS: nxt = target;
                PC_OP_CALL: begin
                    // A full stack turns CALL into a plain step so the
                    // caller never loses its return path silently.
                    if (full) begin
                        nxt     = inc;
                        set_ovf = 1'b1;
                    end else begin
                        nxt  = target;
                        push = 1'b1;
                    end
                end
                PC_OP_RET: begin
                    if (empty) begin
                        nxt     = inc;
                        set_unf = 1'b1;
                    end else begin
                        nxt = stack_top;
                        pop = 1'b1;
                    end
                end
                default: nxt = addr_instr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_instr <= RESET_ADDR;
            stack_ovf  <= 1'b0;
            stack_unf  <= 1'b0;
        end else begin
            addr_instr <= nxt;
            if (do_reset) begin
                stack_ovf <= 1'b0;
                stack_unf <= 1'b0;
            end else begin
                stack_ovf <= stack_ovf | set_ovf;
                stack_unf <= stack_unf | set_unf;
            end
        end
    end

    ret_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (do_reset),
        .push  (push),
        .pop   (pop),
        .din   (inc),
        .dout  (stack_top),
        .full  (full),
        .empty (empty),
        .depth (depth)
    );

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;
    import pc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  op;
    logic [7:0]  k;
    logic [15:0] target;
    logic [7:0]  flags;
    logic [1:0]  cond;
    logic        stall;
    logic [15:0] addr_instr;
    logic [2:0]  depth;
    logic        stack_ovf;
    logic        stack_unf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  dep;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_ovf;
    logic        m_unf;

    pc_stack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .k          (k),
        .target     (target),
        .flags      (flags),
        .cond       (cond),
        .stall      (stall),
        .addr_instr (addr_instr),
        .depth      (depth),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] o, input logic [7:0] kk, input logic [15:0] tg,
                              input logic [7:0] fl, input logic [1:0] cd, input logic st);
        logic [15:0] off;
        logic        tk;
        off = {{8{kk[7]}}, kk} << 1;
        tk  = (cd == 2'b00) ? fl[0] : (cd == 2'b01) ? !fl[0] : (cd == 2'b10) ? fl[1] : 1'b1;
        if (o == 3'b000) begin
            model_reset();
        end else if (!st) begin
            case (o)
                3'b010: m_pc = m_pc + 16'd2;
                3'b011: m_pc = m_pc + off;
                3'b100: m_pc = tk ? m_pc + off : m_pc + 16'd2;
                3'b101: m_pc = tg;
                3'b110: begin
                    if (m_stack.size() == 4) begin
                        m_ovf = 1'b1;
                        m_pc  = m_pc + 16'd2;
                    end else begin
                        m_stack.push_back(m_pc + 16'd2);
                        m_pc = tg;
                    end
                end
                3'b111: begin
                    if (m_stack.size() == 0) begin
                        m_unf = 1'b1;
                        m_pc  = m_pc + 16'd2;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive one op, queue the model's expectation, compare after the edge.
    task automatic step(input string tag, input logic [2:0] o, input logic [7:0] kk,
                        input logic [15:0] tg, input logic [7:0] fl, input logic [1:0] cd,
                        input logic st);
        exp_t e;
        exp_t g;
        op = o; k = kk; target = tg; flags = fl; cond = cd; stall = st;
        model_step(o, kk, tg, fl, cd, st);
        e.pc = m_pc; e.dep = 3'(m_stack.size()); e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({tag, ".pc"},  32'(addr_instr), 32'(g.pc));
        chk({tag, ".dep"}, 32'(depth),      32'(g.dep));
        chk({tag, ".ovf"}, 32'(stack_ovf),  32'(g.ovf));
        chk({tag, ".unf"}, 32'(stack_unf),  32'(g.unf));
        op = PC_OP_HOLD; stall = 1'b0;
    endtask

    initial begin
        op = PC_OP_HOLD; k = '0; target = '0; flags = '0; cond = '0; stall = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst.pc",  32'(addr_instr), 32'h0);
        chk("rst.dep", 32'(depth),      32'h0);
        chk("rst.ovf", 32'(stack_ovf),  32'h0);
        chk("rst.unf", 32'(stack_unf),  32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1. increment
        step("inc1", PC_OP_INC, 8'h00, 16'h0, 8'h00, 2'b00, 1'b0);
        chk("inc1.abs", 32'(addr_instr), 32'h0002);
        step("inc2", PC_OP_INC, 8'h00, 16'h0, 8'h00, 2'b00, 1'b0);
        step("inc3", PC_OP_INC, 8'h00, 16'h0, 8'h00, 2'b00, 1'b0);
        chk("inc3.abs", 32'(addr_instr), 32'h0006);

        // 2. relative jumps
        step("jabs10", PC_OP_JABS, 8'h00, 16'h0010, 8'h00, 2'b00, 1'b0);
        step("jrel_fd", PC_OP_JREL, 8'hFD, 16'h0, 8'h00, 2'b00, 1'b0);
        chk("jrel_fd.abs", 32'(addr_instr), 32'h000A);
        step("jrel_05", PC_OP_JREL, 8'h05, 16'h0, 8'h00, 2'b00, 1'b0);
        chk("jrel_05.abs", 32'(addr_instr), 32'h0014);
        step("jabs02", PC_OP_JABS, 8'h00, 16'h0002, 8'h00, 2'b00, 1'b0);
        step("jrel_wrap", PC_OP_JREL, 8'hFE, 16'h0, 8'h00, 2'b00, 1'b0);
        chk("jrel_wrap.abs", 32'(addr_instr), 32'hFFFE);

        // 3. conditional branches
        step("jabs20a", PC_OP_JABS, 8'h00, 16'h0020, 8'h00, 2'b00, 1'b0);
        step("brc_eq_t", PC_OP_BRC, 8'h04, 16'h0, 8'h01, COND_EQ, 1'b0);
        chk("brc_eq_t.abs", 32'(addr_instr), 32'h0028);
        step("jabs20b", PC_OP_JABS, 8'h00, 16'h0020, 8'h00, 2'b00, 1'b0);
        step("brc_eq_n", PC_OP_BRC, 8'h04, 16'h0, 8'h00, COND_EQ, 1'b0);
        chk("brc_eq_n.abs", 32'(addr_instr), 32'h0022);
        step("jabs20c", PC_OP_JABS, 8'h00, 16'h0020, 8'h00, 2'b00, 1'b0);
        step("brc_grt", PC_OP_BRC, 8'h04, 16'h0, 8'h02, COND_GRT, 1'b0);
        chk("brc_grt.abs", 32'(addr_instr), 32'h0028);
        step("brc_ne_n", PC_OP_BRC, 8'h04, 16'h0, 8'h01, COND_NE, 1'b0);
        step("brc_grt_n", PC_OP_BRC, 8'h04, 16'h0, 8'h01, COND_GRT, 1'b0);
        step("brc_alw", PC_OP_BRC, 8'hFC, 16'h0, 8'h00, COND_ALWAYS, 1'b0);

        // 4. call and return
        step("jabs40", PC_OP_JABS, 8'h00, 16'h0040, 8'h00, 2'b00, 1'b0);
        step("call1", PC_OP_CALL, 8'h00, 16'h0100, 8'h00, 2'b00, 1'b0);
        chk("call1.abs", 32'(addr_instr), 32'h0100);
        step("ret1", PC_OP_RET, 8'h00, 16'h0, 8'h00, 2'b00, 1'b0);
        chk("ret1.abs", 32'(addr_instr), 32'h0042);

        // 5. overflow / underflow
        step("jabs40b", PC_OP_JABS, 8'h00, 16'h0040, 8'h00, 2'b00, 1'b0);
        for (int i = 1; i <= 4; i++)
            step($sformatf("ncall%0d", i), PC_OP_CALL, 8'h00, 16'(i * 16'h0100), 8'h00, 2'b00, 1'b0);
        chk("full.dep", 32'(depth), 32'd4);
        step("call_ovf", PC_OP_CALL, 8'h00, 16'h0500, 8'h00, 2'b00, 1'b0);
        chk("call_ovf.abs", 32'(addr_instr), 32'h0402);
        for (int i = 1; i <= 4; i++)
            step($sformatf("nret%0d", i), PC_OP_RET, 8'h00, 16'h0, 8'h00, 2'b00, 1'b0);
        chk("nret4.abs", 32'(addr_instr), 32'h0042);
        step("ret_unf", PC_OP_RET, 8'h00, 16'h0, 8'h00, 2'b00, 1'b0);
        chk("ret_unf.abs", 32'(addr_instr), 32'h0044);
        step("call_ovf2", PC_OP_CALL, 8'h00, 16'h0700, 8'h00, 2'b00, 1'b0);
        step("opreset", PC_OP_RESET, 8'h00, 16'h0, 8'h00, 2'b00, 1'b0);

        // 6. stall and asynchronous reset
        step("jabs30", PC_OP_JABS, 8'h00, 16'h0030, 8'h00, 2'b00, 1'b0);
        step("call_s", PC_OP_CALL, 8'h00, 16'h0080, 8'h00, 2'b00, 1'b0);
        for (int i = 1; i <= 3; i++)
            step($sformatf("stall_inc%0d", i), PC_OP_INC, 8'h00, 16'h0, 8'h00, 2'b00, 1'b1);
        step("stall_call", PC_OP_CALL, 8'h00, 16'h0900, 8'h00, 2'b00, 1'b1);
        step("stall_ret", PC_OP_RET, 8'h00, 16'h0, 8'h00, 2'b00, 1'b1);
        step("stall_rst", PC_OP_RESET, 8'h00, 16'h0, 8'h00, 2'b00, 1'b1);
        chk("stall_rst.abs", 32'(addr_instr), 32'h0000);

        step("jabs30b", PC_OP_JABS, 8'h00, 16'h0030, 8'h00, 2'b00, 1'b0);
        step("call_a", PC_OP_CALL, 8'h00, 16'h0030, 8'h00, 2'b00, 1'b0);
        op = PC_OP_INC; stall = 1'b1;
        @(posedge clk); #3;
        chk("pre_arst.pc", 32'(addr_instr), 32'h0030);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.pc",  32'(addr_instr), 32'h0000);
        chk("arst.dep", 32'(depth),      32'h0);
        chk("arst.ovf", 32'(stack_ovf),  32'h0);
        @(posedge clk); #1;
        chk("arst_hold.pc", 32'(addr_instr), 32'h0000);
        rst_n = 1'b1;
        step("post_inc", PC_OP_INC, 8'h00, 16'h0, 8'h00, 2'b00, 1'b0);
        chk("post_inc.abs", 32'(addr_instr), 32'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised next-generation program counter for the 8-bit CPU core. It drives the instruction fetch address to the memory block.
- Adds the following over the current PC:
  - configurable address width and instruction stride
  - sign-extended relative jumps of configurable width
  - absolute jumps
  - flag-conditional branches using the ALU EQ/GRT flags
  - hardware return-address stack for CALL/RET, with overflow/underflow detection
  - pipeline stall input

Parameters:
- ADDR_WIDTH, 16, width of the instruction address.
- OFFSET_WIDTH, 8, width of the signed relative offset k (two's complement).
- STRIDE_LOG2, 1, log2 of instruction size in bytes (1 gives a stride of 2).
- STACK_DEPTH, 4, number of return-address entries (>=1).
- RESET_ADDR, 0, address loaded on reset.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  3  operation code (see Behaviour).
- k  in  OFFSET_WIDTH  signed relative offset, counted in instructions.
- target  in  ADDR_WIDTH  absolute target for JABS/CALL.
- flags  in  8  ALU flags; bit0 = EQ, bit1 = GRT.
- cond  in  2  branch condition select for BRC.
- stall  in  1  hold all state this cycle.
- addr_instr  out  ADDR_WIDTH  registered fetch address.
- depth  out  $clog2(STACK_DEPTH+1)  current stack occupancy.
- stack_ovf  out  1  sticky: CALL attempted while the stack was full.
- stack_unf  out  1  sticky: RET attempted while the stack was empty.

Behaviour:
- Reset (rst_n low, asynchronous): addr_instr = RESET_ADDR, depth = 0, stack_ovf = 0, stack_unf = 0. Stack contents are don't-care.
- All updates are registered. The op presented before edge n takes effect on addr_instr at edge n, giving one-cycle latency.
- Define inc = addr_instr + (1<<STRIDE_LOG2) and rel = addr_instr + (sext(k) << STRIDE_LOG2).
- All address arithmetic is modulo 2^ADDR_WIDTH. Wrap-around is silent and is not an error.
- op encodings:
  - 000 RESET: synchronous equivalent of rst_n (PC, depth and sticky flags cleared).
  - 001 HOLD: PC unchanged.
  - 010 INC: PC = inc.
  - 011 JREL: PC = rel.
  - 100 BRC: PC = rel if the condition holds, else inc.
  - 101 JABS: PC = target.
  - 110 CALL: push inc, then PC = target.
  - 111 RET: PC = popped address.
- cond encodings for BRC: 00 EQ (flags[0]), 01 NE (!flags[0]), 10 GRT (flags[1]), 11 always.
- CALL with depth == STACK_DEPTH:
  - no push, no jump; PC = inc
  - stack_ovf set to 1
  - depth unchanged
- RET with depth == 0:
  - PC = inc
  - stack_unf set to 1
  - depth unchanged
- The sticky flags clear only on rst_n or op RESET.
- stall = 1: PC, stack, depth and sticky flags all hold, and op is ignored. The single exception is op RESET, which overrides stall.
- Only one op is accepted per cycle, so push and pop never happen simultaneously.
- No combinational path from op, k, target, flags, cond or stall to addr_instr.
- rst_n asserted mid-CALL or mid-stall: outputs go to their reset values immediately, independent of clk.

Decomposition:
- Shared package pc_pkg holds:
  - op encodings (PC_OP_RESET … PC_OP_RET)
  - cond encodings (COND_EQ, COND_NE, COND_GRT, COND_ALWAYS)
  - flag bit indices EQ_BIT = 0 and GRT_BIT = 1, shared with the alu
- One sub-module, ret_stack: a LIFO of STACK_DEPTH × ADDR_WIDTH.
  - Inputs: push, pop, din.
  - Outputs: dout (top of stack), full, empty, depth.
  - Same clk and rst_n as the parent.
- pc_stack contains only next-address selection, the PC register and the sticky flags.

Test Plan (ADDR_WIDTH 16, STRIDE_LOG2 1, OFFSET_WIDTH 8, STACK_DEPTH 4):
1. Reset and increment: pulse rst_n low, then INC ×3 → addr_instr reads 0x0000, 0x0002, 0x0004, 0x0006; depth = 0.
2. Relative jumps:
   - At 0x0010, JREL k = 0xFD → 0x000A.
   - Then JREL k = 0x05 → 0x0014.
   - At 0x0002, JREL k = 0xFE → 0xFFFE (wrap).
3. Conditional branches from 0x0020, k = 0x04:
   - BRC cond = EQ, flags = 0x01 → 0x0028.
   - Repeat with flags = 0x00 → 0x0022.
   - cond = GRT with flags = 0x02 → taken.
4. Call and return: at 0x0040, CALL target = 0x0100 → PC 0x0100, depth 1. Then RET → PC 0x0042, depth 0.
5. Stack overflow and underflow:
   - Four nested CALLs fill the stack (depth 4).
   - A fifth CALL → PC = previous + 2, stack_ovf = 1, depth 4.
   - Four RETs return to the pushed addresses in LIFO order.
   - A fifth RET → stack_unf = 1, PC = previous + 2.
   - op RESET then clears both flags.
6. Stall and asynchronous reset:
   - stall = 1 with op = INC for 3 cycles → PC unchanged.
   - stall = 1 with op = RESET → PC 0x0000.
   - rst_n driven low between clock edges while stalled at 0x0030 → addr_instr = 0x0000 before the next rising edge.
